// File: rtl/fpu_thread_scheduler.sv
// Two-thread FP issue scheduler with div/sqrt ownership tracking and E1..W tag pipeline.
// Build option: define FPU_SCHED_RR_EN for round-robin arbitration (default is fixed priority, thread 0 first).
//
// state | meaning
// IDLE  | div/sqrt unit free, either thread may issue a div/sqrt op
// BUSY0 | div/sqrt unit owned by thread 0, thread 0 blocked entirely
// BUSY1 | div/sqrt unit owned by thread 1, thread 1 blocked entirely
module fpu_thread_scheduler (
  input  logic clk,
  input  logic clrn,
  input  logic ena,
  input  logic fp_req0,
  input  logic fp_req1,
  input  logic fp_dsq0,
  input  logic fp_dsq1,
  input  logic dsq_done,
  output logic grant0,
  output logic grant1,
  output logic dt,
  output logic e1t,
  output logic e2t,
  output logic e3t,
  output logic wt,
  output logic e1v,
  output logic e2v,
  output logic e3v,
  output logic wv,
  output logic stall0,
  output logic stall1,
  output logic dsq_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } dsq_state_t;

  dsq_state_t state;
  logic       lg;
  logic       elig0;
  logic       elig1;
  logic       pick1;

  // Eligibility uses the registered state only, so a dsq_done arriving this
  // cycle cannot free the unit for a div/sqrt request in the same cycle.
  always_comb begin
    elig0 = fp_req0 & ena & (state != BUSY0) & ~(fp_dsq0 & (state != IDLE));
    elig1 = fp_req1 & ena & (state != BUSY1) & ~(fp_dsq1 & (state != IDLE));
`ifdef FPU_SCHED_RR_EN
    pick1 = elig1 & (~elig0 | ~lg);
`else
    pick1 = elig1 & ~elig0;
`endif
    grant1 = pick1;
    grant0 = elig0 & ~pick1;
    dt     = pick1;
    stall0 = fp_req0 & ~grant0;
    stall1 = fp_req1 & ~grant1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= IDLE;
      dsq_busy <= 1'b0;
      lg       <= 1'b1;
    end else begin
      if (grant0 | grant1) begin
        lg <= grant1;
      end
      case (state)
        IDLE: begin
          if (grant0 & fp_dsq0) begin
            state    <= BUSY0;
            dsq_busy <= 1'b1;
          end else if (grant1 & fp_dsq1) begin
            state    <= BUSY1;
            dsq_busy <= 1'b1;
          end
        end
        BUSY0, BUSY1: begin
          // completion frees the unit even while the pipeline is frozen
          if (dsq_done) begin
            state    <= IDLE;
            dsq_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          dsq_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      e1t <= 1'b0;
      e2t <= 1'b0;
      e3t <= 1'b0;
      wt  <= 1'b0;
      e1v <= 1'b0;
      e2v <= 1'b0;
      e3v <= 1'b0;
      wv  <= 1'b0;
    end else if (ena) begin
      e1t <= dt;
      e2t <= e1t;
      e3t <= e2t;
      wt  <= e3t;
      e1v <= grant0 | grant1;
      e2v <= e1v;
      e3v <= e2v;
      wv  <= e3v;
    end
  end

endmodule

// File: tb/tb_fpu_thread_scheduler.sv
// Directed self-checking bench for fpu_thread_scheduler; expectations follow FPU_SCHED_RR_EN if defined.
module tb_fpu_thread_scheduler;

  logic clk = 1'b0;
  logic clrn, ena, fp_req0, fp_req1, fp_dsq0, fp_dsq1, dsq_done;
  logic grant0, grant1, dt, e1t, e2t, e3t, wt, e1v, e2v, e3v, wv;
  logic stall0, stall1, dsq_busy;

  int checks = 0;
  int failures = 0;

`ifdef FPU_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  fpu_thread_scheduler dut (
    .clk(clk), .clrn(clrn), .ena(ena),
    .fp_req0(fp_req0), .fp_req1(fp_req1),
    .fp_dsq0(fp_dsq0), .fp_dsq1(fp_dsq1), .dsq_done(dsq_done),
    .grant0(grant0), .grant1(grant1), .dt(dt),
    .e1t(e1t), .e2t(e2t), .e3t(e3t), .wt(wt),
    .e1v(e1v), .e2v(e2v), .e3v(e3v), .wv(wv),
    .stall0(stall0), .stall1(stall1), .dsq_busy(dsq_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // drive inputs mid-low-phase, then let combinational outputs settle
  task automatic drive(input logic c, input logic e, input logic r0, input logic r1,
                       input logic d0, input logic d1, input logic done);
    clrn = c; ena = e; fp_req0 = r0; fp_req1 = r1;
    fp_dsq0 = d0; fp_dsq1 = d1; dsq_done = done;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic chk_grants(input string tag, input logic g0, input logic g1,
                            input logic s0, input logic s1);
    chk({tag, "_grant0"}, grant0, g0);
    chk({tag, "_grant1"}, grant1, g1);
    chk({tag, "_dt"}, dt, g1);
    chk({tag, "_stall0"}, stall0, s0);
    chk({tag, "_stall1"}, stall1, s1);
  endtask

  task automatic chk_pipe(input string tag, input logic [3:0] tags, input logic [3:0] vals);
    chk({tag, "_e1t"}, e1t, tags[3]);
    chk({tag, "_e2t"}, e2t, tags[2]);
    chk({tag, "_e3t"}, e3t, tags[1]);
    chk({tag, "_wt"},  wt,  tags[0]);
    chk({tag, "_e1v"}, e1v, vals[3]);
    chk({tag, "_e2v"}, e2v, vals[2]);
    chk({tag, "_e3v"}, e3v, vals[1]);
    chk({tag, "_wv"},  wv,  vals[0]);
  endtask

  initial begin
    @(negedge clk);
    // reset
    drive(0, 1, 1, 1, 0, 0, 0);
    next();
    next();
    chk("rst_busy", dsq_busy, 1'b0);
    chk_pipe("rst", 4'b0000, 4'b0000);

    // both threads non-dsq for 4 cycles; lg=1 after reset so RR starts with thread 0
    drive(1, 1, 1, 1, 0, 0, 0);
    chk_grants("arb_c0", 1'b1, 1'b0, 1'b0, 1'b1);
    next();
    drive(1, 1, 1, 1, 0, 0, 0);
    chk_grants("arb_c1", !RR, RR, RR, !RR);
    next();
    drive(1, 1, 1, 1, 0, 0, 0);
    chk_grants("arb_c2", 1'b1, 1'b0, 1'b0, 1'b1);
    next();
    drive(1, 1, 1, 1, 0, 0, 0);
    chk_grants("arb_c3", !RR, RR, RR, !RR);
    next();
    drive(1, 1, 0, 0, 0, 0, 0);
    chk_grants("arb_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_pipe("arb_pipe", RR ? 4'b1010 : 4'b0000, 4'b1111);
    next();

    // thread 0 takes the div/sqrt unit
    drive(1, 1, 1, 0, 1, 0, 0);
    chk_grants("dsq0_issue", 1'b1, 1'b0, 1'b0, 1'b0);
    next();
    chk("dsq0_busy", dsq_busy, 1'b1);
    drive(1, 1, 1, 1, 0, 0, 0);
    chk_grants("busy0_t1op", 1'b0, 1'b1, 1'b1, 1'b0);
    next();
    drive(1, 1, 1, 1, 0, 1, 0);
    chk_grants("busy0_t1dsq", 1'b0, 1'b0, 1'b1, 1'b1);
    next();
    drive(1, 1, 1, 1, 0, 0, 1);
    chk_grants("busy0_done", 1'b0, 1'b1, 1'b1, 1'b0);
    next();
    chk("dsq0_freed", dsq_busy, 1'b0);
    drive(1, 1, 1, 0, 0, 0, 0);
    chk_grants("idle_t0op", 1'b1, 1'b0, 1'b0, 1'b0);
    next();

    // BUSY1, then dsq_done coincides with a thread-0 dsq request
    drive(1, 1, 0, 1, 0, 1, 0);
    chk_grants("dsq1_issue", 1'b0, 1'b1, 1'b0, 1'b0);
    next();
    chk("dsq1_busy", dsq_busy, 1'b1);
    drive(1, 1, 1, 0, 1, 0, 1);
    chk_grants("busy1_same", 1'b0, 1'b0, 1'b1, 1'b0);
    next();
    chk("busy1_freed", dsq_busy, 1'b0);
    drive(1, 1, 1, 0, 1, 0, 0);
    chk_grants("busy1_next", 1'b1, 1'b0, 1'b0, 1'b0);
    next();
    chk("busy0_after", dsq_busy, 1'b1);
    drive(1, 1, 1, 1, 0, 0, 0);
    chk_grants("busy0_owner", 1'b0, 1'b1, 1'b1, 1'b0);
    next();

    // completion while frozen still frees the unit
    drive(1, 0, 1, 1, 0, 0, 1);
    chk_grants("frz_done", 1'b0, 1'b0, 1'b1, 1'b1);
    next();
    chk("frz_freed", dsq_busy, 1'b0);

    // reset in the middle of a thread-0 div/sqrt
    drive(1, 1, 1, 0, 1, 0, 0);
    chk_grants("rst_dsq_issue", 1'b1, 1'b0, 1'b0, 1'b0);
    next();
    chk("rst_pre_busy", dsq_busy, 1'b1);
    drive(0, 1, 1, 1, 0, 0, 0);
    next();
    chk("rst_mid_busy", dsq_busy, 1'b0);
    chk_pipe("rst_mid", 4'b0000, 4'b0000);
    drive(1, 1, 0, 0, 0, 0, 1);
    next();
    chk("rst_stray_done", dsq_busy, 1'b0);
    // still IDLE, so thread 0 dsq issues and owns the unit
    drive(1, 1, 1, 0, 1, 0, 0);
    chk_grants("rst_post_dsq", 1'b1, 1'b0, 1'b0, 1'b0);
    next();
    chk("rst_post_busy", dsq_busy, 1'b1);
    drive(1, 1, 0, 0, 0, 0, 1);
    next();

    // tag pipeline with a one-cycle freeze
    drive(1, 1, 0, 0, 0, 0, 0);
    next();
    next();
    next();
    next();
    chk_pipe("pipe_flush", 4'b0000, 4'b0000);
    drive(1, 1, 0, 1, 0, 0, 0);
    chk_grants("pipe_c0", 1'b0, 1'b1, 1'b0, 1'b0);
    next();
    chk_pipe("pipe_c1", 4'b1000, 4'b1000);
    drive(1, 1, 0, 0, 0, 0, 0);
    next();
    chk_pipe("pipe_c2", 4'b0100, 4'b0100);
    drive(1, 0, 1, 1, 0, 0, 0);
    chk_grants("pipe_frz", 1'b0, 1'b0, 1'b1, 1'b1);
    next();
    chk_pipe("pipe_c3", 4'b0100, 4'b0100);
    drive(1, 1, 0, 0, 0, 0, 0);
    next();
    chk_pipe("pipe_c4", 4'b0010, 4'b0010);
    next();
    chk_pipe("pipe_c5", 4'b0001, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
